// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer, valid/ready handshake,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W          = 32,
    parameter bit          CLEAR_ON_BUBBLE = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = main_v_q & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;

        unique case ({main_v_q, skid_v_q})
            2'b00: begin
                if (in_fire) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end
            end
            2'b10: begin
                if (in_fire && out_fire) begin
                    main_d_d = in_data;
                end else if (in_fire) begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end else if (out_fire) begin
                    main_v_d = 1'b0;
                    if (CLEAR_ON_BUBBLE) main_d_d = '0;
                end
            end
            2'b11: begin
                if (out_fire) begin
                    main_d_d = skid_d_q;
                    skid_v_d = 1'b0;
                    if (CLEAR_ON_BUBBLE) skid_d_d = '0;
                end
            end
            default: begin
                // Unreachable skid-only state: recover to empty.
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
            end
        endcase

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d_d = CLEAR_ON_BUBBLE ? '0 : main_d_q;
            skid_d_d = CLEAR_ON_BUBBLE ? '0 : skid_d_q;
        end

        in_ready_d = !(main_v_d && skid_v_d);

        stall_cnt_d = stall_cnt_q;
        if (main_v_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_d_q    <= '0;
            skid_d_q    <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_d_q    <= main_d_d;
            skid_d_q    <= skid_d_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
